// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch (SS.hh) with start/stop, lap freeze and clear keys.
// Keys are debounced levels; each acts once on its rising edge.
module bcd_stopwatch #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_ss,
  input  logic       key_lap,
  input  logic       key_clr,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       lap_active,
  output logic       ovf
);

  localparam int unsigned   PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_TERM = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_ss_q;
  logic            r_lap_q;
  logic            r_clr_q;
  logic            r_armed;
  logic            w_req_ss;
  logic            w_req_lap;
  logic            w_req_clr;
  logic            w_snap_ld;
  logic            w_counting;
  logic            w_tick;
  logic            w_wrap;
  logic [PW-1:0]   r_presc;
  logic [15:0]     r_cnt;
  logic [15:0]     r_snap;
  logic            r_ovf;
  logic [15:0]     w_disp;

  // Increment a {c3,c2,c1,c0} BCD count; c3 wraps at 5, the rest at 9.
  // Using >= keeps any out-of-range digit from propagating.
  function automatic logic [15:0] bcd_inc(input logic [15:0] c);
    logic [15:0] n;
    logic        carry;
    logic [3:0]  lim;
    n     = c;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lim = (i == 3) ? 4'd5 : 4'd9;
      if (carry) begin
        if (c[i*4 +: 4] >= lim) begin
          n[i*4 +: 4] = 4'd0;
        end else begin
          n[i*4 +: 4] = c[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return n;
  endfunction

  // r_armed suppresses requests on the first edge after reset so a key held
  // through reset release is seen as already pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_q  <= 1'b0;
      r_lap_q <= 1'b0;
      r_clr_q <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_ss_q  <= key_ss;
      r_lap_q <= key_lap;
      r_clr_q <= key_clr;
      r_armed <= 1'b1;
    end
  end

  // Priority clr > ss > lap; losers are dropped.
  assign w_req_clr = r_armed & key_clr & ~r_clr_q;
  assign w_req_ss  = r_armed & key_ss  & ~r_ss_q  & ~w_req_clr;
  assign w_req_lap = r_armed & key_lap & ~r_lap_q & ~w_req_clr & ~w_req_ss;

  assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_tick     = w_counting && (r_presc == PRESC_TERM);
  assign w_wrap     = (r_cnt == 16'h5999);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_snap_ld   = 1'b0;
    if (w_req_clr) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_ss) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (w_req_ss) begin
            w_state_nxt = S_PAUSE;
          end else if (w_req_lap) begin
            w_state_nxt = S_LAP;
            w_snap_ld   = 1'b1;
          end
        end
        S_LAP: begin
          if (w_req_ss) begin
            w_state_nxt = S_PAUSE;
          end else if (w_req_lap) begin
            w_state_nxt = S_RUN;
          end
        end
        S_PAUSE: begin
          if (w_req_ss) w_state_nxt = S_RUN;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Prescaler and count follow the current state, so a tick on the edge
  // that enters PAUSE still lands, while one on a clear edge is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_cnt   <= 16'h0000;
      r_snap  <= 16'h0000;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= w_tick & w_wrap & ~w_req_clr;
      if (w_req_clr || (r_state == S_IDLE)) begin
        r_presc <= '0;
        r_cnt   <= 16'h0000;
      end else if (w_counting) begin
        r_presc <= w_tick ? '0 : (r_presc + PW'(1));
        if (w_tick) r_cnt <= bcd_inc(r_cnt);
      end
      if (w_req_clr) begin
        r_snap <= 16'h0000;
      end else if (w_snap_ld) begin
        r_snap <= r_cnt;
      end
    end
  end

  assign w_disp     = (r_state == S_LAP) ? r_snap : r_cnt;
  assign d0         = w_disp[3:0];
  assign d1         = w_disp[7:4];
  assign d2         = w_disp[11:8];
  assign d3         = w_disp[15:12];
  assign running    = w_counting;
  assign lap_active = (r_state == S_LAP);
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch: a centisecond-level model queues the
// expected outputs for every clock edge and a monitor compares them.
module tb_bcd_stopwatch;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_ss = 1'b0;
  logic       key_lap = 1'b0;
  logic       key_clr = 1'b0;
  logic [3:0] d0, d1, d2, d3;
  logic       running, lap_active, ovf;

  bcd_stopwatch #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_ss    (key_ss),
    .key_lap   (key_lap),
    .key_clr   (key_clr),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .running   (running),
    .lap_active(lap_active),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  ph;
    logic [18:0] v;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   phase = 0;
  int   ovf_seen = 0;

  // Reference model state: elapsed time in centiseconds.
  int m_st, m_cs, m_presc, m_snap;
  bit m_ovf, m_just, m_pss, m_plap, m_pclr;

  function automatic logic [15:0] to_bcd(input int cs);
    return {4'(cs / 1000), 4'((cs / 100) % 10), 4'((cs / 10) % 10), 4'(cs % 10)};
  endfunction

  function automatic logic [18:0] m_out();
    int shown;
    shown = (m_st == M_LAP) ? m_snap : m_cs;
    return {to_bcd(shown), (m_st == M_RUN || m_st == M_LAP), (m_st == M_LAP), m_ovf};
  endfunction

  function automatic void m_reset();
    m_st = M_IDLE; m_cs = 0; m_presc = 0; m_snap = 0;
    m_ovf = 0; m_just = 1; m_pss = 0; m_plap = 0; m_pclr = 0;
  endfunction

  function automatic void m_step(input bit s, input bit l, input bit c);
    bit rs, rl, rc, live;
    int old_cs;
    rc = c && !m_pclr && !m_just;
    rs = s && !m_pss && !m_just && !rc;
    rl = l && !m_plap && !m_just && !rc && !rs;
    m_pss = s; m_plap = l; m_pclr = c; m_just = 0;
    old_cs = m_cs;
    m_ovf = 0;
    if (rc) begin
      m_st = M_IDLE; m_cs = 0; m_presc = 0; m_snap = 0;
      return;
    end
    live = (m_st == M_RUN) || (m_st == M_LAP);
    if (live) begin
      if (m_presc == TD - 1) begin
        m_presc = 0;
        if (m_cs == 5999) begin
          m_cs = 0; m_ovf = 1;
        end else begin
          m_cs = m_cs + 1;
        end
      end else begin
        m_presc = m_presc + 1;
      end
    end else if (m_st == M_IDLE) begin
      m_presc = 0; m_cs = 0;
    end
    case (m_st)
      M_IDLE:  if (rs) m_st = M_RUN;
      M_RUN:   if (rs) m_st = M_PAUSE;
               else if (rl) begin m_st = M_LAP; m_snap = old_cs; end
      M_LAP:   if (rs) m_st = M_PAUSE;
               else if (rl) m_st = M_RUN;
      default: if (rs) m_st = M_RUN;
    endcase
  endfunction

  task automatic push_exp();
    exp_t e;
    e.ph = 8'(phase);
    e.v  = m_out();
    sbq.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // One clock: drive keys before the edge and queue what that edge must produce.
  task automatic cyc(input bit s, input bit l, input bit c);
    @(negedge clk);
    key_ss = s; key_lap = l; key_clr = c;
    m_step(s, l, c);
    push_exp();
  endtask

  task automatic do_reset(input int n, input bit hold);
    @(negedge clk);
    rst_n = 1'b0; key_ss = hold; key_lap = 1'b0; key_clr = 1'b0;
    m_reset();
    push_exp();
    #1;
    check("async_rst", {d3, d2, d1, d0, running, lap_active, ovf}, 32'h0);
    repeat (n - 1) begin
      @(negedge clk);
      push_exp();
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_step(hold, 1'b0, 1'b0);
    push_exp();
  endtask

  // Monitor: the outputs after every edge are compared with the queued entry.
  initial begin
    exp_t        e;
    logic [18:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e   = sbq.pop_front();
        got = {d3, d2, d1, d0, running, lap_active, ovf};
        total++;
        if (got !== e.v) begin
          bad++;
          $display("FAIL out ph=%0d got=%h want=%h", e.ph, got, e.v);
        end
        if (ovf === 1'b1) ovf_seen++;
      end
    end
  end

  initial begin
    int lat, guard, ovf0;
    bit s, l, c;
    m_reset();

    // Start from IDLE: first count change exactly TD cycles after the ss edge.
    phase = 1;
    do_reset(3, 1'b0);
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      cyc(0, 0, 0);
      if (lat < 0 && d0 !== 4'd0) lat = n - 1;
    end
    check("start_lat", lat, TD);
    repeat (29) cyc(0, 0, 0);
    check("run40_digits", {d1, d0}, 8'h10);
    check("run40_running", running, 1);

    // Count up to 59.98, then through the wrap.
    phase = 2;
    cyc(0, 0, 1); cyc(0, 0, 0);
    cyc(1, 0, 0); cyc(0, 0, 0);
    guard = 0;
    while (m_cs != 5998 && guard < 30000) begin
      cyc(0, 0, 0);
      guard++;
    end
    check("reach_5998", guard < 30000, 1);
    ovf0 = ovf_seen;
    repeat (12) cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("ovf_pulses", ovf_seen - ovf0, 1);
    check("after_wrap_d3", d3, 4'd0);

    // Lap freeze and release.
    phase = 3;
    cyc(0, 0, 1); cyc(0, 0, 0);
    cyc(1, 0, 0); cyc(0, 0, 0);
    guard = 0;
    while (m_cs != 5 && guard < 100) begin
      cyc(0, 0, 0);
      guard++;
    end
    cyc(0, 1, 0); cyc(0, 0, 0);
    repeat (20) cyc(0, 0, 0);
    check("lap_hold", {d3, d2, d1, d0}, 16'h0005);
    check("lap_active", lap_active, 1);
    cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    check("lap_release", lap_active, 0);
    check("lap_rel_running", running, 1);

    // Pause with a partial prescaler step, then resume.
    phase = 4;
    guard = 0;
    while (!(m_presc == 2 && m_st == M_RUN) && guard < 20) begin
      cyc(0, 0, 0);
      guard++;
    end
    cyc(1, 0, 0);
    repeat (100) cyc(0, 0, 0);
    check("pause_digits", {d3, d2, d1, d0}, to_bcd(m_cs));
    check("pause_running", running, 0);
    cyc(1, 0, 0);
    lat = -1;
    for (int n = 1; n <= 6; n++) begin
      cyc(0, 0, 0);
      if (lat < 0 && {d3, d2, d1, d0} !== to_bcd(m_cs - 1)) lat = n - 1;
    end
    check("resume_lat", lat, 1);

    // All three keys at once while running, then reset with ss held.
    phase = 5;
    repeat (9) cyc(0, 0, 0);
    cyc(1, 1, 1); cyc(0, 0, 0); cyc(0, 0, 0);
    check("simul_digits", {d3, d2, d1, d0}, 16'h0000);
    check("simul_running", running, 0);
    cyc(1, 0, 0); cyc(0, 0, 0);
    repeat (10) cyc(0, 0, 0);
    cyc(1, 0, 0);
    do_reset(2, 1'b1);
    repeat (10) cyc(1, 0, 0);
    check("rst_hold_running", running, 0);
    check("rst_hold_digits", {d3, d2, d1, d0}, 16'h0000);
    cyc(0, 0, 0);

    // Random key activity with occasional resets.
    phase = 6;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(int'($urandom_range(1, 3)), bit'($urandom_range(0, 1)));
      end else begin
        s = key_ss  ^ ($urandom_range(0, 7) == 0);
        l = key_lap ^ ($urandom_range(0, 9) == 0);
        c = key_clr ^ ($urandom_range(0, 59) == 0);
        cyc(s, l, c);
      end
    end

    guard = 0;
    while (sbq.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    check("drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
